seg7_scan: RTL

- Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
- Captures a DIGITS-nibble hex value (e.g. PC, register or bus value from the MIPS datapath) via a load strobe.
- Presents one nibble at a time on DOUT, which drives the hex-to-segment decoder input, together with an active-low digit select.
- A new value is applied only at a frame boundary, so one scan never shows two different values.

---
 rtl/seg7_scan.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/seg7_scan.sv
// -----------------------------------------------------------------------------
// seg7_scan
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment
// display. A DIGITS-nibble value is captured into a pending register on LOAD
// and promoted to the displayed copy only at a frame boundary (the tick that
// lights digit 0), so a single scan never mixes two values.
//
// Optional build macro: SEG7_BLANK_LZ_EN
//   defined   -> leading-zero blanking (digit 0 is never blanked)
//   undefined -> every digit is lit in its slot
// -----------------------------------------------------------------------------
module seg7_scan #(
    parameter int DIGITS = 8,
    parameter int DIV    = 50000,
    parameter int DIV_W  = 16
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [4*DIGITS-1:0]   DATA,
    input  logic                  LOAD,
    output logic                  BUSY,
    output logic [3:0]            DOUT,
    output logic [DIGITS-1:0]     nDIG,
    output logic                  FRAME
);

    localparam int               IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] PRESC_ONE  = DIV_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

    logic [DIV_W-1:0]    r_presc;
    logic [IDX_W-1:0]    r_idx;
    logic [4*DIGITS-1:0] r_shown;
    logic [4*DIGITS-1:0] r_pending;
    logic                r_busy;
    logic [3:0]          r_dout;
    logic [DIGITS-1:0]   r_ndig;
    logic                r_frame;

    logic                w_tick;
    logic                w_boundary;
    logic [4*DIGITS-1:0] w_shown_next;
    logic [3:0]          w_nib;
    logic [DIGITS-1:0]   w_sel;
    logic                w_blank;

    assign w_tick       = (r_presc == DIV_LAST);
    assign w_boundary   = w_tick && (r_idx == '0);
    // At a frame boundary with a value waiting, digit 0 already shows the new value.
    assign w_shown_next = (w_boundary && r_busy) ? r_pending : r_shown;

    // Prescaler: counts 0..DIV-1 and wraps; tick marks the last count of a slot.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!nRST) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRESC_ONE;
        end
    end

    // Pick the nibble and the active-high one-hot enable for the current slot.
    always_comb begin
        // NOTE: defaults first so no path leaves a combinational output unassigned
        // (which would infer a latch).
        w_nib = '0;
        w_sel = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib    = w_shown_next[4*i +: 4];
                w_sel[i] = 1'b1;
            end
        end
    end

`ifdef SEG7_BLANK_LZ_EN
    logic [DIGITS-1:0] w_lz;

    // Leading-zero detection: w_lz[i] is set when nibbles i..DIGITS-1 are all zero.
    always_comb begin
        logic v_all_zero;
        v_all_zero = 1'b1;
        w_lz       = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            v_all_zero = v_all_zero && (w_shown_next[4*i +: 4] == 4'h0);
            w_lz[i]    = v_all_zero;
        end
        // Digit 0 always shows, so a zero value still displays a single "0".
        w_lz[0] = 1'b0;
    end

    assign w_blank = |(w_sel & w_lz);
`else
    assign w_blank = 1'b0;
`endif

    // Scan outputs: on each tick present the current digit and advance the index.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_idx   <= '0;
            r_dout  <= '0;
            r_ndig  <= '1;
            r_frame <= 1'b0;
        end else begin
            r_frame <= w_boundary;
            if (w_tick) begin
                r_dout <= w_nib;
                r_ndig <= w_blank ? '1 : ~w_sel;
                r_idx  <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_ONE;
            end
        end
    end

    // Value capture: LOAD writes pending; a frame boundary promotes pending to shown.
    always_ff @(posedge CLK) begin
        // NOTE: the wide data registers are reset as well, so a reset mid-frame
        // discards whatever value was waiting and the display restarts from zero.
        if (!nRST) begin
            r_shown   <= '0;
            r_pending <= '0;
            r_busy    <= 1'b0;
        end else begin
            if (w_boundary && r_busy) begin
                r_shown <= r_pending;
                r_busy  <= 1'b0;
            end
            // A LOAD on the same edge wins: new data is pending and BUSY stays set.
            if (LOAD) begin
                r_pending <= DATA;
                r_busy    <= 1'b1;
            end
        end
    end

    assign BUSY  = r_busy;
    assign DOUT  = r_dout;
    assign nDIG  = r_ndig;
    assign FRAME = r_frame;

endmodule
